// File: rtl/icache.sv
// icache: direct-mapped 128-bit-line instruction cache, blocking on miss; ICACHE_STATS_EN adds hit/miss counters
module icache #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cpu_req,
  input  logic [11:0]  cpu_addr,
  input  logic         flush,
  output logic         cpu_ready,
  output logic         instr_valid,
  output logic [31:0]  instr_out,
  output logic         mem_req_out,
  output logic [7:0]   mem_addr,
  input  logic [127:0] mem_data_in,
  input  logic         mem_done_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 8 - INDEX_W;
  localparam int TW = (TAG_W > 0) ? TAG_W : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic [127:0] data [NUM_LINES];
  logic [TW-1:0] tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic flush_pend;
  logic [1:0] word_q;
  logic hit;
  logic [31:0] hit_word;
  logic unused_addr_bits;
  function automatic logic [INDEX_W-1:0] idx_of(input logic [7:0] la);
    return INDEX_W'(la);
  endfunction
  function automatic logic [TW-1:0] tag_of(input logic [7:0] la);
    return TW'(la >> INDEX_W);
  endfunction
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign cpu_ready = (state == IDLE) && !flush && !flush_pend;
  assign hit = valid[idx_of(cpu_addr[11:4])] && (tags[idx_of(cpu_addr[11:4])] == tag_of(cpu_addr[11:4]));
  assign hit_word = data[idx_of(cpu_addr[11:4])][{cpu_addr[3:2], 5'b0} +: 32];
  // lookup/refill FSM with registered response and memory request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      valid <= '0;
      flush_pend <= 1'b0;
      instr_valid <= 1'b0;
      instr_out <= '0;
      mem_req_out <= 1'b0;
      mem_addr <= '0;
      word_q <= '0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            valid <= '0;
            flush_pend <= 1'b0;
          end else if (cpu_req) begin
            word_q <= cpu_addr[3:2];
            if (hit) begin
              instr_out <= hit_word;
              instr_valid <= 1'b1;
            end else begin
              state <= REQ;
              mem_req_out <= 1'b1;
              mem_addr <= cpu_addr[11:4];
            end
          end
        end
        REQ: begin
          if (flush) flush_pend <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_done_in) begin
            valid[idx_of(mem_addr)] <= 1'b1;
            instr_out <= mem_data_in[{word_q, 5'b0} +: 32];
            instr_valid <= 1'b1;
            mem_req_out <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // line storage written on refill completion; reset aborts the fill
  always_ff @(posedge clk) begin
    if (reset_n && state == WAIT && mem_done_in) begin
      data[idx_of(mem_addr)] <= mem_data_in;
      tags[idx_of(mem_addr)] <= tag_of(mem_addr);
    end
  end
`ifdef ICACHE_STATS_EN
  // saturating hit/miss counters over accepted requests
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (cpu_ready && cpu_req) begin
      if (hit && ~&hit_count) hit_count <= hit_count + 16'd1;
      if (!hit && ~&miss_count) miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache
module tb_icache;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_req = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic flush = 1'b0;
  logic cpu_ready;
  logic instr_valid;
  logic [31:0] instr_out;
  logic mem_req_out;
  logic [7:0] mem_addr;
  logic [127:0] mem_data_in = '0;
  logic mem_done_in = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  icache dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_ready(cpu_ready), .instr_valid(instr_valid), .instr_out(instr_out),
    .mem_req_out(mem_req_out), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_done_in(mem_done_in)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  function automatic logic [127:0] line_of(input logic [7:0] la);
    return {la, 8'd3, 16'hC0DE, la, 8'd2, 16'hC0DE, la, 8'd1, 16'hC0DE, la, 8'd0, 16'hC0DE};
  endfunction
  function automatic logic [31:0] word_of(input logic [11:0] a);
    logic [127:0] l;
    l = line_of(a[11:4]);
    return l[{a[3:2], 5'b0} +: 32];
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_hit(input logic [11:0] a);
    cpu_req = 1'b1;
    cpu_addr = a;
    tick();
    cpu_req = 1'b0;
    chk("hit_valid", 32'(instr_valid), 32'd1);
    chk("hit_data", instr_out, word_of(a));
    chk("hit_no_mem", 32'(mem_req_out), 32'd0);
  endtask
  task automatic do_miss(input logic [11:0] a, input int lat);
    cpu_req = 1'b1;
    cpu_addr = a;
    tick();
    cpu_req = 1'b0;
    chk("miss_req0", 32'(mem_req_out), 32'd1);
    chk("miss_addr", 32'(mem_addr), 32'(a[11:4]));
    chk("miss_ready0", 32'(cpu_ready), 32'd0);
    mem_data_in = line_of(a[11:4]);
    mem_done_in = 1'b1;
    tick();
    chk("miss_req1", 32'(mem_req_out), 32'd1);
    chk("miss_novalid", 32'(instr_valid), 32'd0);
    mem_done_in = 1'b0;
    repeat (lat) begin
      tick();
      chk("miss_wait_req", 32'(mem_req_out), 32'd1);
      chk("miss_wait_novalid", 32'(instr_valid), 32'd0);
    end
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    chk("fill_valid", 32'(instr_valid), 32'd1);
    chk("fill_data", instr_out, word_of(a));
    chk("fill_req_drop", 32'(mem_req_out), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_iout", instr_out, 32'd0);
    chk("rst_mreq", 32'(mem_req_out), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    do_miss(12'h010, 0);
    tick();
    chk("pulse_end", 32'(instr_valid), 32'd0);
    chk("out_hold", instr_out, 32'h0100C0DE);
    do_hit(12'h01C);
    do_hit(12'h014);
    do_miss(12'h110, 0);
    do_hit(12'h118);
    do_miss(12'h010, 2);
    do_hit(12'h010);
    flush = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 12'h014;
    #1;
    chk("flush_ready", 32'(cpu_ready), 32'd0);
    tick();
    flush = 1'b0;
    cpu_req = 1'b0;
    chk("flush_drop_valid", 32'(instr_valid), 32'd0);
    chk("flush_drop_mreq", 32'(mem_req_out), 32'd0);
    do_miss(12'h010, 0);
    cpu_req = 1'b1;
    cpu_addr = 12'h024;
    tick();
    cpu_req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_data_in = line_of(8'h02);
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    chk("wflush_valid", 32'(instr_valid), 32'd1);
    chk("wflush_data", instr_out, 32'h0201C0DE);
    chk("wflush_pend_ready", 32'(cpu_ready), 32'd0);
    tick();
    chk("wflush_ready_back", 32'(cpu_ready), 32'd1);
    do_miss(12'h024, 0);
    do_miss(12'h030, 0);
    cpu_req = 1'b1;
    cpu_addr = 12'h044;
    tick();
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b0;
    mem_data_in = line_of(8'h04);
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    reset_n = 1'b1;
    chk("midrst_mreq", 32'(mem_req_out), 32'd0);
    chk("midrst_ivalid", 32'(instr_valid), 32'd0);
    chk("midrst_ready", 32'(cpu_ready), 32'd1);
    do_miss(12'h044, 0);
    do_miss(12'h030, 0);
`ifdef ICACHE_STATS_EN
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("st_rst_hit", 32'(hit_count), 32'd0);
    chk("st_rst_miss", 32'(miss_count), 32'd0);
    do_miss(12'h050, 0);
    do_hit(12'h050);
    do_hit(12'h054);
    do_hit(12'h058);
    chk("st_hits", 32'(hit_count), 32'd3);
    chk("st_misses", 32'(miss_count), 32'd1);
    force dut.hit_count = 16'hFFFF;
    tick();
    release dut.hit_count;
    do_hit(12'h05C);
    do_hit(12'h050);
    chk("st_sat", 32'(hit_count), 32'h0000FFFF);
    chk("st_miss_kept", 32'(miss_count), 32'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
